// File: rtl/hazard_controller.sv
// Hazard unit for the 5-stage MIPS pipeline: operand forwarding, load-use/branch stalls,
// multi-cycle-op hold FSM and saturating stall/flush event counters.
module hazard_controller #(
  parameter int REG_W      = 5,
  parameter int MC_LATENCY = 4,
  parameter int DELAY_SLOT = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MultiCycleE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             RegWriteW,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic {IDLE = 1'b0, MC_BUSY = 1'b1} mcState_t;

  // Counter only has to reach MC_LATENCY-2; the first held cycle is spent in IDLE.
  localparam int              MC_W    = (MC_LATENCY > 2) ? $clog2(MC_LATENCY - 1) : 1;
  localparam logic [MC_W-1:0] MC_LOAD = MC_W'(MC_LATENCY - 2);
  localparam logic            SQUASH  = (DELAY_SLOT == 0);

  mcState_t        state, stateNext;
  logic [MC_W-1:0] mcCnt, mcCntNext;
  logic            mcHold;
  logic            lwStall;
  logic            brStall;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt, input logic en);
    if (en && (cnt != {CNT_W{1'b1}})) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  function automatic logic [1:0] fwdSel(input logic [REG_W-1:0] srcId,
                                        input logic wrM, input logic [REG_W-1:0] idM,
                                        input logic wrW, input logic [REG_W-1:0] idW);
    if (wrM && (idM != '0) && (idM == srcId)) return 2'b10;
    if (wrW && (idW != '0) && (idW == srcId)) return 2'b01;
    return 2'b00;
  endfunction

  assign lwStall = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
  assign brStall = BranchD &&
                   ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));

  always_comb begin
    stateNext = state;
    mcCntNext = mcCnt;
    mcHold    = 1'b0;
    case (state)
      IDLE: begin
        if (MultiCycleE) begin
          stateNext = MC_BUSY;
          mcCntNext = MC_LOAD;
          mcHold    = 1'b1;
        end
      end
      MC_BUSY: begin
        if (mcCnt != '0) begin
          mcCntNext = mcCnt - MC_W'(1);
          mcHold    = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    if (reset_n) begin
      ForwardAE = fwdSel(RsE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardBE = fwdSel(RtE, RegWriteM, WriteRegM, RegWriteW, WriteRegW);
      ForwardAD = RegWriteM && (WriteRegM != '0) && (WriteRegM == RsD);
      ForwardBD = RegWriteM && (WriteRegM != '0) && (WriteRegM == RtD);
      // A held multi-cycle op freezes F/D/E and bubbles M; it takes priority over data stalls.
      if (mcHold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (lwStall || brStall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      FlushD = PCSrcD && !StallD && SQUASH;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      mcCnt      <= '0;
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      state      <= stateNext;
      mcCnt      <= mcCntNext;
      StallCount <= satInc(StallCount, StallF);
      FlushCount <= satInc(FlushCount, FlushD | FlushE);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: expected output vectors are queued when a cycle's
// stimulus is driven and compared at the following falling edge.
module tb_hazard_controller;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,ForwardAE,ForwardBE,ForwardAD,ForwardBD,StallCount,FlushCount}
  typedef logic [19:0] vec_t;
  typedef struct { string name; vec_t exp; } sb_t;

  logic             clock;
  logic             reset_n;
  logic [REG_W-1:0] RsD, RtD, RsE, RtE;
  logic             BranchD, PCSrcD, MultiCycleE;
  logic [REG_W-1:0] WriteRegE, WriteRegM, WriteRegW;
  logic             RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             ForwardAD, ForwardBD;
  logic [CNT_W-1:0] StallCount, FlushCount;
  logic             dsStallF, dsStallD, dsStallE, dsFlushD, dsFlushE, dsFlushM;
  logic [1:0]       dsForwardAE, dsForwardBE;
  logic             dsForwardAD, dsForwardBD;
  logic [CNT_W-1:0] dsStallCount, dsFlushCount;

  sb_t sbQ[$];
  int  nChecks = 0;
  int  nFail   = 0;
  int  expStall = 0;
  int  expFlush = 0;

  hazard_controller #(.REG_W(REG_W), .MC_LATENCY(4), .DELAY_SLOT(0), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MultiCycleE(MultiCycleE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
    .ForwardBD(ForwardBD), .StallCount(StallCount), .FlushCount(FlushCount)
  );

  hazard_controller #(.REG_W(REG_W), .MC_LATENCY(4), .DELAY_SLOT(1), .CNT_W(CNT_W)) dutDs (
    .clock(clock), .reset_n(reset_n), .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .MultiCycleE(MultiCycleE),
    .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
    .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
    .StallF(dsStallF), .StallD(dsStallD), .StallE(dsStallE), .FlushD(dsFlushD), .FlushE(dsFlushE),
    .FlushM(dsFlushM), .ForwardAE(dsForwardAE), .ForwardBE(dsForwardBE), .ForwardAD(dsForwardAD),
    .ForwardBD(dsForwardBD), .StallCount(dsStallCount), .FlushCount(dsFlushCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t outs();
    return {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE,
            ForwardAD, ForwardBD, StallCount, FlushCount};
  endfunction

  function automatic vec_t mk(input bit sf, input bit sd, input bit se, input bit fd,
                              input bit fe, input bit fm, input bit [1:0] fae,
                              input bit [1:0] fbe, input bit fad, input bit fbd);
    return {sf, sd, se, fd, fe, fm, fae, fbe, fad, fbd, 4'(expStall), 4'(expFlush)};
  endfunction

  // Advance the counter model by what the coming rising edge should record.
  task automatic accum(input vec_t e);
    if (!reset_n) begin
      expStall = 0;
      expFlush = 0;
    end else begin
      if (e[19] && expStall < SAT) expStall++;
      if ((e[16] || e[15]) && expFlush < SAT) expFlush++;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clearIn();
    reset_n = 1'b1;
    RsD = '0; RtD = '0; RsE = '0; RtE = '0;
    BranchD = 1'b0; PCSrcD = 1'b0; MultiCycleE = 1'b0;
    WriteRegE = '0; RegWriteE = 1'b0; MemtoRegE = 1'b0;
    WriteRegM = '0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
    WriteRegW = '0; RegWriteW = 1'b0;
  endtask

  task automatic test_reset();
    sb_t s;
    vec_t got;
    for (int k = 0; k < 2; k++) begin
      tick();
      clearIn();
      if (k == 0) begin
        reset_n = 1'b0;
        MemtoRegE = 1'b1; RtE = 5'd2; RsD = 5'd2; RtD = 5'd7;
        RegWriteM = 1'b1; WriteRegM = 5'd2; RsE = 5'd2; PCSrcD = 1'b1; MultiCycleE = 1'b1;
        sbQ.push_back('{"reset_forced", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      end else begin
        sbQ.push_back('{"reset_release", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      end
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      accum(s.exp);
    end
  endtask

  task automatic test_lw_stall();
    sb_t s;
    vec_t got;
    for (int k = 0; k < 4; k++) begin
      tick();
      clearIn();
      case (k)
        0: begin
          MemtoRegE = 1'b1; RtE = 5'd2; RsD = 5'd2; RtD = 5'd7;
          sbQ.push_back('{"lw_rs", mk(1,1,0,0,1,0,2'b00,2'b00,0,0)});
        end
        1: sbQ.push_back('{"lw_released", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        2: begin
          MemtoRegE = 1'b1; RtE = 5'd4; RsD = 5'd1; RtD = 5'd4;
          sbQ.push_back('{"lw_rt", mk(1,1,0,0,1,0,2'b00,2'b00,0,0)});
        end
        default: begin
          MemtoRegE = 1'b1; RtE = 5'd4; RsD = 5'd1; RtD = 5'd2;
          sbQ.push_back('{"lw_nodep", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        end
      endcase
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      accum(s.exp);
    end
  endtask

  task automatic test_forward();
    sb_t s;
    vec_t got;
    for (int k = 0; k < 6; k++) begin
      tick();
      clearIn();
      case (k)
        0: begin
          RegWriteM = 1'b1; WriteRegM = 5'd3; RegWriteW = 1'b1; WriteRegW = 5'd3; RsE = 5'd3;
          sbQ.push_back('{"fwd_m_beats_w", mk(0,0,0,0,0,0,2'b10,2'b00,0,0)});
        end
        1: begin
          RegWriteM = 1'b1; WriteRegM = 5'd0; RegWriteW = 1'b1; WriteRegW = 5'd3; RsE = 5'd3;
          sbQ.push_back('{"fwd_m_reg0_w", mk(0,0,0,0,0,0,2'b01,2'b00,0,0)});
        end
        2: begin
          RegWriteM = 1'b1; WriteRegM = 5'd0; RegWriteW = 1'b1; WriteRegW = 5'd0;
          sbQ.push_back('{"fwd_reg0", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        end
        3: begin
          RegWriteM = 1'b0; WriteRegM = 5'd6; RegWriteW = 1'b1; WriteRegW = 5'd6;
          RsE = 5'd6; RtE = 5'd6;
          sbQ.push_back('{"fwd_w_both", mk(0,0,0,0,0,0,2'b01,2'b01,0,0)});
        end
        4: begin
          RegWriteM = 1'b1; WriteRegM = 5'd9; RsD = 5'd9; RtD = 5'd9; RsE = 5'd1; RtE = 5'd2;
          RegWriteW = 1'b1; WriteRegW = 5'd2;
          sbQ.push_back('{"fwd_d_branch", mk(0,0,0,0,0,0,2'b00,2'b01,1,1)});
        end
        default: begin
          RegWriteW = 1'b1; WriteRegW = 5'd9; RsD = 5'd9; RtD = 5'd9;
          sbQ.push_back('{"fwd_d_no_w", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        end
      endcase
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      accum(s.exp);
    end
  endtask

  task automatic test_branch();
    sb_t s;
    vec_t got;
    for (int k = 0; k < 5; k++) begin
      tick();
      clearIn();
      case (k)
        0: begin
          BranchD = 1'b1; PCSrcD = 1'b1; RsD = 5'd1; RtD = 5'd2;
          sbQ.push_back('{"br_taken_squash", mk(0,0,0,1,0,0,2'b00,2'b00,0,0)});
        end
        1: begin
          BranchD = 1'b1; PCSrcD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd5; RsD = 5'd5; RtD = 5'd1;
          sbQ.push_back('{"br_stall_e", mk(1,1,0,0,1,0,2'b00,2'b00,0,0)});
        end
        2: begin
          BranchD = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd8; RsD = 5'd1; RtD = 5'd8;
          sbQ.push_back('{"br_stall_m_load", mk(1,1,0,0,1,0,2'b00,2'b00,0,0)});
        end
        3: begin
          BranchD = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd0; MemtoRegM = 1'b1; WriteRegM = 5'd0;
          sbQ.push_back('{"br_reg0_nostall", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        end
        default: begin
          RegWriteE = 1'b1; WriteRegE = 5'd5; RsD = 5'd5; RtD = 5'd1;
          sbQ.push_back('{"br_not_branch", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        end
      endcase
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      if (k == 0) begin
        nChecks++;
        if (dsFlushD !== 1'b0) begin
          nFail++;
          $display("FAIL delay_slot_flushd: got %b expected 0", dsFlushD);
        end
      end
      accum(s.exp);
    end
  endtask

  task automatic test_multicycle();
    sb_t s;
    vec_t got;
    int startStall;
    startStall = expStall;
    for (int k = 0; k < 5; k++) begin
      tick();
      clearIn();
      case (k)
        0: begin
          MultiCycleE = 1'b1;
          sbQ.push_back('{"mc_start", mk(1,1,1,0,0,1,2'b00,2'b00,0,0)});
        end
        1: begin
          MemtoRegE = 1'b1; RtE = 5'd2; RsD = 5'd2; RtD = 5'd7;
          sbQ.push_back('{"mc_over_lw", mk(1,1,1,0,0,1,2'b00,2'b00,0,0)});
        end
        2: begin
          PCSrcD = 1'b1;
          sbQ.push_back('{"mc_no_flushd", mk(1,1,1,0,0,1,2'b00,2'b00,0,0)});
        end
        3: sbQ.push_back('{"mc_release", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        default: sbQ.push_back('{"mc_idle", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      endcase
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      if (k == 3) begin
        nChecks++;
        if (StallCount !== 4'(startStall + 3)) begin
          nFail++;
          $display("FAIL mc_stallcount: got %0d expected %0d", StallCount, startStall + 3);
        end
      end
      accum(s.exp);
    end
  endtask

  task automatic test_back_to_back();
    sb_t s;
    vec_t got;
    bit hold;
    for (int k = 0; k < 9; k++) begin
      tick();
      clearIn();
      MultiCycleE = (k <= 4);
      hold = (k < 3) || (k >= 4 && k < 7);
      if (hold) sbQ.push_back('{$sformatf("b2b_hold_%0d", k), mk(1,1,1,0,0,1,2'b00,2'b00,0,0)});
      else      sbQ.push_back('{$sformatf("b2b_free_%0d", k), mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      accum(s.exp);
    end
  endtask

  task automatic test_saturation();
    sb_t s;
    vec_t got;
    for (int k = 0; k < 21; k++) begin
      tick();
      clearIn();
      if (k < 20) begin
        MemtoRegE = 1'b1; RtE = 5'd3; RsD = 5'd3; RtD = 5'd1;
        sbQ.push_back('{$sformatf("sat_stall_%0d", k), mk(1,1,0,0,1,0,2'b00,2'b00,0,0)});
      end else begin
        sbQ.push_back('{"sat_idle", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      end
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      accum(s.exp);
    end
    nChecks++;
    if (StallCount !== 4'd15 || FlushCount !== 4'd15) begin
      nFail++;
      $display("FAIL sat_counters: got %0d/%0d expected 15/15", StallCount, FlushCount);
    end
  endtask

  task automatic test_reset_mid_mc();
    sb_t s;
    vec_t got;
    for (int k = 0; k < 4; k++) begin
      tick();
      clearIn();
      case (k)
        0: begin
          MultiCycleE = 1'b1;
          sbQ.push_back('{"rmc_start", mk(1,1,1,0,0,1,2'b00,2'b00,0,0)});
        end
        1: begin
          reset_n = 1'b0; MultiCycleE = 1'b1;
          MemtoRegE = 1'b1; RtE = 5'd2; RsD = 5'd2; RtD = 5'd7;
          sbQ.push_back('{"rmc_in_reset", mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
        end
        default: sbQ.push_back('{$sformatf("rmc_after_%0d", k), mk(0,0,0,0,0,0,2'b00,2'b00,0,0)});
      endcase
      @(negedge clock);
      s = sbQ.pop_front();
      got = outs();
      nChecks++;
      if (got !== s.exp) begin
        nFail++;
        $display("FAIL %s: got %h expected %h", s.name, got, s.exp);
      end
      if (k == 2) begin
        nChecks++;
        if (StallE !== 1'b0 || StallCount !== '0 || FlushCount !== '0) begin
          nFail++;
          $display("FAIL rmc_aborted: got StallE=%b cnt=%0d/%0d expected 0 0/0",
                   StallE, StallCount, FlushCount);
        end
      end
      accum(s.exp);
    end
  endtask

  initial begin
    clearIn();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    expStall = 0;
    expFlush = 0;
    test_reset();
    test_lw_stall();
    test_forward();
    test_branch();
    test_multicycle();
    test_back_to_back();
    test_saturation();
    test_reset_mid_mc();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
